// File: rtl/keccak_pkg.sv
// Shared Keccak configuration helpers: round count, slice schedule, FSM encoding.
package keccak_pkg;

  localparam int unsigned ROUND_BITS = 5;
  localparam int unsigned MAX_ROUNDS = 24;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Standard round count for lane width w: 12 + 2*log2(w)
  function automatic int unsigned nr_rounds(input int unsigned w);
    return 32'(12 + 2 * $clog2(w));
  endfunction

  // Last slice step that carries round-constant work
  function automatic int unsigned slice_end(input int unsigned w,
                                            input int unsigned sp,
                                            input int unsigned dom_pipeline,
                                            input int unsigned sbox_1cycle);
    int unsigned steps;
    steps = w / sp;
    if ((dom_pipeline == 0) && (sbox_1cycle == 0)) begin
      return 2 * steps - 1;
    end
    return steps - 1;
  endfunction

  // Last slice step of a round, including the DOM drain cycle when present
  function automatic int unsigned slice_last(input int unsigned w,
                                             input int unsigned sp,
                                             input int unsigned dom_pipeline,
                                             input int unsigned sbox_1cycle);
    return slice_end(w, sp, dom_pipeline, sbox_1cycle) + ((dom_pipeline != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/keccak_wrap_counter.sv
// Wrapping up-counter 0..MAX with enable and synchronous clear.
module keccak_wrap_counter #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned MAX   = 16
) (
  input  logic             ClkxCI,
  input  logic             RstxRI,
  input  logic             EnxSI,
  input  logic             ClrxSI,
  output logic [WIDTH-1:0] CntxDO,
  output logic [WIDTH-1:0] CntNextxDO,
  output logic             WrapxSO
);

  // MAX must be representable in the counter
  if (MAX >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("keccak_wrap_counter: MAX does not fit in WIDTH bits");
  end

  // Counter sits at its wrap point; enabling it now returns it to zero
  assign WrapxSO = (CntxDO == WIDTH'(MAX));

  // Next value: clear wins, explicit wrap at MAX, otherwise hold or increment
  always_comb begin
    CntNextxDO = CntxDO;
    if (ClrxSI) begin
      CntNextxDO = '0;
    end else if (EnxSI) begin
      CntNextxDO = WrapxSO ? '0 : CntxDO + WIDTH'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      CntxDO <= '0;
    end else begin
      CntxDO <= CntNextxDO;
    end
  end

endmodule

// File: rtl/keccak_round_control.sv
// Round/slice sequencer driving the round-constant generator and datapath.
module keccak_round_control
  import keccak_pkg::*;
#(
  parameter int unsigned W                = 16,
  parameter int unsigned COUNTER_BITWIDTH = 4,
  parameter int unsigned SLICES_PARALLEL  = 1,
  parameter int unsigned DOM_PIPELINE     = 1,
  parameter int unsigned SBOX_1CYCLE      = 0,
  parameter int unsigned NR_ROUNDS        = 20
) (
  input  logic                        ClkxCI,
  input  logic                        RstxRI,
  input  logic                        StartxSI,
  input  logic                        StallxSI,
  output logic                        BusyxSO,
  output logic                        DonexSO,
  output logic [ROUND_BITS-1:0]       RoundNrxDO,
  output logic [COUNTER_BITWIDTH:0]   SliceNrxDO,
  output logic [COUNTER_BITWIDTH:0]   NextSliceNrxDO,
  output logic                        ResetRCxSO,
  output logic                        EnableRCxSO,
  output logic                        LastSlicexSO,
  output logic                        LastRoundxSO
);

  localparam int unsigned CNT_W      = COUNTER_BITWIDTH + 1;
  localparam int unsigned SLICE_END  = slice_end(W, SLICES_PARALLEL, DOM_PIPELINE, SBOX_1CYCLE);
  localparam int unsigned SLICE_LAST = slice_last(W, SLICES_PARALLEL, DOM_PIPELINE, SBOX_1CYCLE);

  // Configuration sanity checks
  if (SLICES_PARALLEL == 0 || (W % SLICES_PARALLEL) != 0) begin : g_bad_sp
    $error("keccak_round_control: W must be divisible by SLICES_PARALLEL");
  end
  if (SLICE_LAST >= (64'd1 << CNT_W)) begin : g_bad_cnt
    $error("keccak_round_control: slice counter too narrow for SLICE_LAST");
  end
  if (NR_ROUNDS == 0 || NR_ROUNDS > MAX_ROUNDS) begin : g_bad_rounds
    $error("keccak_round_control: NR_ROUNDS out of range");
  end

  state_t state_q;
  state_t state_d;

  logic             slice_en;
  logic             round_en;
  logic             cnt_clr;
  logic             slice_wrap;
  logic             round_wrap;
  logic             final_step;
  logic [CNT_W-1:0] slice_next;
  logic [ROUND_BITS-1:0] round_next_unused;

  // Slice step counter, wraps after the drain/last slice of each round
  keccak_wrap_counter #(
    .WIDTH (CNT_W),
    .MAX   (SLICE_LAST)
  ) u_slice_cnt (
    .ClkxCI     (ClkxCI),
    .RstxRI     (RstxRI),
    .EnxSI      (slice_en),
    .ClrxSI     (cnt_clr),
    .CntxDO     (SliceNrxDO),
    .CntNextxDO (slice_next),
    .WrapxSO    (slice_wrap)
  );

  // Round counter, advanced on every slice wrap except the final one
  keccak_wrap_counter #(
    .WIDTH (ROUND_BITS),
    .MAX   (NR_ROUNDS - 1)
  ) u_round_cnt (
    .ClkxCI     (ClkxCI),
    .RstxRI     (RstxRI),
    .EnxSI      (round_en),
    .ClrxSI     (cnt_clr),
    .CntxDO     (RoundNrxDO),
    .CntNextxDO (round_next_unused),
    .WrapxSO    (round_wrap)
  );

  // Last slice of the last round: counters freeze here and the FSM finishes
  assign final_step   = slice_wrap && round_wrap;
  assign LastSlicexSO = slice_wrap;
  assign LastRoundxSO = round_wrap;

  // State register
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a stall holds RUN even on the final step
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (StartxSI) state_d = ST_RUN;
      ST_RUN:  if (!StallxSI && final_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and counter-control decode
  always_comb begin
    BusyxSO        = 1'b0;
    DonexSO        = 1'b0;
    ResetRCxSO     = 1'b0;
    EnableRCxSO    = 1'b0;
    NextSliceNrxDO = '0;
    slice_en       = 1'b0;
    round_en       = 1'b0;
    cnt_clr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ResetRCxSO = StartxSI;
        cnt_clr    = StartxSI;
      end
      ST_RUN: begin
        BusyxSO        = 1'b1;
        EnableRCxSO    = (SliceNrxDO <= CNT_W'(SLICE_END));
        slice_en       = !StallxSI && !final_step;
        round_en       = !StallxSI && slice_wrap && !round_wrap;
        NextSliceNrxDO = slice_next;
      end
      ST_DONE: begin
        BusyxSO        = 1'b1;
        DonexSO        = 1'b1;
        NextSliceNrxDO = slice_next;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_round_control.sv
// Scoreboard bench for keccak_round_control: default config and a 2-cycle-slice config.
`timescale 1ns/1ps
module tb_keccak_round_control;

  localparam int unsigned NR = 20;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rrc;
    logic       erc;
    logic       ls;
    logic       lr;
    logic [4:0] round;
    logic [4:0] slice;
    logic [4:0] nslice;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] stall;
  logic [1:0] busy_o, done_o, rrc_o, erc_o, ls_o, lr_o;
  logic [4:0] round_o  [2];
  logic [4:0] slice_o  [2];
  logic [4:0] nslice_o [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          cyc     = 0;
  int          m_state [2];
  int          m_round [2];
  int          m_slice [2];
  int          start_cyc [2];
  int          stall_cnt [2];
  int          en_cnt    [2];
  int          done_cnt  [2];
  int          done_cyc  [2];
  logic        seen_done [2];
  exp_t        sb [$];

  always #5 clk = ~clk;

  keccak_round_control dut0 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start[0]), .StallxSI(stall[0]),
    .BusyxSO(busy_o[0]), .DonexSO(done_o[0]), .RoundNrxDO(round_o[0]),
    .SliceNrxDO(slice_o[0]), .NextSliceNrxDO(nslice_o[0]), .ResetRCxSO(rrc_o[0]),
    .EnableRCxSO(erc_o[0]), .LastSlicexSO(ls_o[0]), .LastRoundxSO(lr_o[0])
  );

  keccak_round_control #(.DOM_PIPELINE(0), .SBOX_1CYCLE(0)) dut1 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start[1]), .StallxSI(stall[1]),
    .BusyxSO(busy_o[1]), .DonexSO(done_o[1]), .RoundNrxDO(round_o[1]),
    .SliceNrxDO(slice_o[1]), .NextSliceNrxDO(nslice_o[1]), .ResetRCxSO(rrc_o[1]),
    .EnableRCxSO(erc_o[1]), .LastSlicexSO(ls_o[1]), .LastRoundxSO(lr_o[1])
  );

  // Per-instance schedule: inst0 = 16 work + 1 drain; inst1 = 32 work, no drain
  function automatic int slice_end_of(input int i);
    return (i == 0) ? 15 : 31;
  endfunction

  function automatic int slice_last_of(input int i);
    return (i == 0) ? 16 : 31;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle given the inputs being applied
  function automatic exp_t model_out(input int i, input logic st, input logic stl);
    exp_t e;
    e.busy   = (m_state[i] != 0);
    e.done   = (m_state[i] == 2);
    e.rrc    = (m_state[i] == 0) && st;
    e.erc    = (m_state[i] == 1) && (m_slice[i] <= slice_end_of(i));
    e.ls     = (m_slice[i] == slice_last_of(i));
    e.lr     = (m_round[i] == NR - 1);
    e.round  = 5'(m_round[i]);
    e.slice  = 5'(m_slice[i]);
    if (m_state[i] == 0)                          e.nslice = 5'd0;
    else if (m_state[i] == 2 || stl)              e.nslice = 5'(m_slice[i]);
    else if (m_slice[i] == slice_last_of(i))      e.nslice = (m_round[i] == NR - 1) ? 5'(m_slice[i]) : 5'd0;
    else                                          e.nslice = 5'(m_slice[i] + 1);
    return e;
  endfunction

  task automatic model_tick(input int i, input logic r, input logic st, input logic stl);
    if (r) begin
      m_state[i] = 0; m_round[i] = 0; m_slice[i] = 0;
    end else begin
      case (m_state[i])
        0: if (st) begin m_state[i] = 1; m_round[i] = 0; m_slice[i] = 0; end
        1: if (!stl) begin
             if (m_slice[i] == slice_last_of(i)) begin
               if (m_round[i] == NR - 1) m_state[i] = 2;
               else begin m_slice[i] = 0; m_round[i] = m_round[i] + 1; end
             end else begin
               m_slice[i] = m_slice[i] + 1;
             end
           end
        default: m_state[i] = 0;
      endcase
    end
  endtask

  task automatic compare_outputs(input int i, input exp_t e);
    check_eq($sformatf("i%0d busy", i),   32'(busy_o[i]),   32'(e.busy));
    check_eq($sformatf("i%0d done", i),   32'(done_o[i]),   32'(e.done));
    check_eq($sformatf("i%0d rst_rc", i), 32'(rrc_o[i]),    32'(e.rrc));
    check_eq($sformatf("i%0d en_rc", i),  32'(erc_o[i]),    32'(e.erc));
    check_eq($sformatf("i%0d last_sl", i),32'(ls_o[i]),     32'(e.ls));
    check_eq($sformatf("i%0d last_rd", i),32'(lr_o[i]),     32'(e.lr));
    check_eq($sformatf("i%0d round", i),  32'(round_o[i]),  32'(e.round));
    check_eq($sformatf("i%0d slice", i),  32'(slice_o[i]),  32'(e.slice));
    check_eq($sformatf("i%0d nslice", i), 32'(nslice_o[i]), 32'(e.nslice));
  endtask

  // One clock: drive at negedge, push expectations, pop and compare, advance model
  task automatic step(input logic r, input logic [1:0] st, input logic [1:0] stl);
    exp_t e;
    @(negedge clk);
    rst = r; start = st; stall = stl;
    for (int i = 0; i < 2; i++) sb.push_back(model_out(i, st[i], stl[i]));
    #1;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      compare_outputs(i, e);
      if (!r && e.rrc) begin
        start_cyc[i] = cyc; stall_cnt[i] = 0; en_cnt[i] = 0;
      end
      if (!r && m_state[i] == 1 && stl[i]) stall_cnt[i]++;
      if (erc_o[i] === 1'b1) en_cnt[i]++;
      if (done_o[i] === 1'b1) begin
        seen_done[i] = 1'b1;
        done_cnt[i]++;
        done_cyc[i] = cyc;
        check_eq($sformatf("i%0d done latency", i), 32'(cyc - start_cyc[i]),
                 32'((slice_last_of(i) + 1) * NR + 1 + stall_cnt[i]));
        if (stall_cnt[i] == 0)
          check_eq($sformatf("i%0d enable count", i), 32'(en_cnt[i]),
                   32'((slice_end_of(i) + 1) * NR));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_tick(i, r, st[i], stl[i]);
    cyc++;
  endtask

  task automatic run_to_done(input int i, input logic [1:0] st, input int budget);
    seen_done[i] = 1'b0;
    for (int k = 0; k < budget && !seen_done[i]; k++) step(1'b0, st, 2'b00);
    check_eq($sformatf("i%0d done reached", i), 32'(seen_done[i]), 32'd1);
  endtask

  task automatic advance_to(input int i, input int rnd, input int slc, input int budget);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      if (m_state[i] == 1 && m_round[i] == rnd && m_slice[i] == slc) hit = 1'b1;
      else step(1'b0, 2'b00, 2'b00);
    end
    check_eq($sformatf("i%0d reached r%0d s%0d", i, rnd, slc), 32'(hit), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_before;
    int d_first;
    rst = 1'b1; start = 2'b00; stall = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_round[i] = 0; m_slice[i] = 0;
      start_cyc[i] = 0; stall_cnt[i] = 0; en_cnt[i] = 0;
      done_cnt[i] = 0; done_cyc[i] = 0; seen_done[i] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 2'b00, 2'b00);
    step(1'b0, 2'b00, 2'b00);

    // Plain runs on both configurations
    step(1'b0, 2'b11, 2'b00);
    run_to_done(0, 2'b00, 400);
    run_to_done(1, 2'b00, 400);
    step(1'b0, 2'b00, 2'b00);

    // Stall 5 cycles at round 3, slice 7
    step(1'b0, 2'b01, 2'b00);
    advance_to(0, 3, 7, 100);
    repeat (5) step(1'b0, 2'b00, 2'b01);
    run_to_done(0, 2'b00, 400);
    check_eq("stall cycles counted", 32'(stall_cnt[0]), 32'd5);
    step(1'b0, 2'b00, 2'b00);

    // Start held continuously: back-to-back runs
    step(1'b0, 2'b01, 2'b00);
    run_to_done(0, 2'b01, 400);
    d_first = done_cyc[0];
    run_to_done(0, 2'b01, 400);
    check_eq("back-to-back done gap", 32'(done_cyc[0] - d_first), 32'd342);
    step(1'b0, 2'b00, 2'b00);
    step(1'b0, 2'b00, 2'b00);

    // Reset in round 10, then a fresh run
    step(1'b0, 2'b01, 2'b00);
    advance_to(0, 10, 0, 250);
    d_before = done_cnt[0];
    step(1'b1, 2'b00, 2'b00);
    repeat (3) step(1'b0, 2'b00, 2'b00);
    check_eq("no done after reset", 32'(done_cnt[0]), 32'(d_before));
    step(1'b0, 2'b01, 2'b00);
    run_to_done(0, 2'b00, 400);
    step(1'b0, 2'b00, 2'b00);

    // Stall on the very last RUN cycle
    step(1'b0, 2'b01, 2'b00);
    advance_to(0, 19, 16, 400);
    repeat (3) step(1'b0, 2'b00, 2'b01);
    run_to_done(0, 2'b00, 10);
    check_eq("final-edge stall cycles", 32'(stall_cnt[0]), 32'd3);
    step(1'b0, 2'b00, 2'b00);

    check_eq("i0 total dones", 32'(done_cnt[0]), 32'd6);
    check_eq("i1 total dones", 32'(done_cnt[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_round_control.md
# keccak_round_control

Round/slice sequencer for the slice-serial DOM Keccak core. It is the initiator side of the round-constant interface. It steps round and slice counters, drives RoundNr/SliceNr/NextSliceNr/ResetRC/EnableRC into keccak_roundconstant and the datapath, and exposes a start/busy/done handshake to the top-level controller. A stall input freezes sequencing while fresh randomness is unavailable.

## Interface
- W, 16, lane width; slices per state.
- COUNTER_BITWIDTH, 4, slice counter width minus one; counter is COUNTER_BITWIDTH+1 bits.
- SLICES_PARALLEL, 1, slices processed per step; W divisible by it.
- DOM_PIPELINE, 1, 1 = one extra drain cycle per round.
- SBOX_1CYCLE, 0, with DOM_PIPELINE=0: 0 = two cycles per slice step.
- NR_ROUNDS, 20, rounds per permutation (12+2·log2(W)); at most 24.
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  reset; synchronous, active-high.
- StartxSI  in  1  start permutation; sampled in IDLE only.
- StallxSI  in  1  hold all counters this cycle.
- BusyxSO  out  1  high in RUN and DONE.
- DonexSO  out  1  one-cycle pulse at completion.
- RoundNrxDO  out  5  current round.
- SliceNrxDO  out  COUNTER_BITWIDTH+1  current slice step.
- NextSliceNrxDO  out  COUNTER_BITWIDTH+1  value SliceNrxDO takes next cycle.
- ResetRCxSO  out  1  round-constant reset.
- EnableRCxSO  out  1  round-constant enable.
- LastSlicexSO  out  1  SliceNrxDO == SLICE_LAST.
- LastRoundxSO  out  1  RoundNrxDO == NR_ROUNDS-1.

## Operation
- Constants:
  - STEPS = W/SLICES_PARALLEL.
  - SLICE_END = 2·STEPS−1 if (!DOM_PIPELINE && !SBOX_1CYCLE); otherwise STEPS−1.
  - SLICE_LAST = SLICE_END+DOM_PIPELINE.
  - CYC_PER_ROUND = SLICE_LAST+1.
- Elaboration check: SLICE_LAST < 2^(COUNTER_BITWIDTH+1); NR_ROUNDS ≤ 24.
- States:
  - IDLE: on StartxSI go to RUN, and Round and Slice load 0. ResetRCxSO = StartxSI (combinational). StallxSI is ignored.
  - RUN: if StallxSI, everything holds. Otherwise Slice increments. At SLICE_LAST, Slice wraps to 0 and Round increments. At SLICE_LAST with Round == NR_ROUNDS−1, go to DONE.
  - DONE: DonexSO=1 for exactly one cycle, then IDLE. Counters hold their final values.
- EnableRCxSO = RUN && SliceNr ≤ SLICE_END. It is low during the drain cycle (SliceNr == SLICE_END+1, DOM_PIPELINE only). It is not gated by stall.
- NextSliceNrxDO is combinational:
  - equals SliceNr when stalled or in DONE;
  - 0 in IDLE and at wrap;
  - SliceNr+1 otherwise.
- Counter arithmetic is unsigned at full width. The wrap is explicit and never relies on overflow.
- StartxSI in RUN or DONE is ignored. It is not queued.

## Timing
- Reset values: state IDLE, RoundNr=0, SliceNr=0, BusyxSO=0, DonexSO=0, EnableRCxSO=0. LastSlicexSO and LastRoundxSO are derived from the reset counters.
- RstxRI mid-RUN: next edge forces IDLE. No DonexSO is emitted.
- Start accepted at edge t:
  - RUN from t+1.
  - DONE at t+1+NR_ROUNDS·CYC_PER_ROUND+S, where S is the number of stalled RUN cycles.
- Defaults (W=16, SP=1, DOM_PIPELINE=1): CYC_PER_ROUND=17, RUN lasts 340 cycles, DonexSO one cycle later.
- Stall in the last RUN cycle delays DONE by one cycle per stall cycle.
- Back-to-back: StartxSI high in the cycle after DONE (IDLE) is accepted. Minimum gap between runs is one DONE plus one IDLE cycle.

## Structure
- Shared package keccak_pkg:
  - function nr_rounds(W);
  - state encoding localparams (IDLE/RUN/DONE);
  - SLICE_END/SLICE_LAST computation function, shared with keccak_roundconstant configuration checks.
- Sub-module keccak_wrap_counter: parameterised width, MAX, enable, clear. Outputs the count, its next value, and a wrap flag. Instantiated for the slice counter and the round counter.
- FSM and output decode live in this module.

## Test plan
- Reset then Start with defaults (20 rounds, 17 cycles/round):
  - ResetRCxSO=1 in the start cycle;
  - EnableRCxSO high 16 of every 17 cycles;
  - single DonexSO 341 cycles after start;
  - RoundNr sequence 0..19.
- DOM_PIPELINE=0, SBOX_1CYCLE=0: SliceNr counts 0..31, EnableRCxSO never drops, and DonexSO arrives 641 cycles after start.
- StallxSI held 5 cycles in round 3, slice 7: counters and NextSliceNr frozen; DonexSO delayed by exactly 5 cycles.
- StartxSI held continuously: runs repeat with one DONE plus one IDLE cycle between them; StartxSI pulses in RUN have no effect.
- RstxRI asserted in round 10: IDLE next cycle, all outputs at reset values, no DonexSO; a new Start completes normally.
- Final edge: stall asserted exactly on slice 16 of round 19 → DONE deferred; LastSlicexSO and LastRoundxSO both high throughout the stall.
